// File: rtl/demux1_2.sv
// 1:2 demultiplexer with a small registered FIFO on each output channel.
// sel picks the channel; each channel drains independently via its ready.
module demux1_2_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_valid = (r_cnt != '0);
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_count = r_cnt;
  assign o_data  = r_mem[r_rd];

  // A full FIFO never takes a push, even when popped in the same cycle.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_ready & o_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

module demux1_2 #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         x,
  output logic                     x_valid,
  input  logic                     x_ready,
  output logic [WIDTH-1:0]         y,
  output logic                     y_valid,
  input  logic                     y_ready,
  output logic [$clog2(DEPTH):0]   x_count,
  output logic [$clog2(DEPTH):0]   y_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic w_x_full;
  logic w_y_full;
  logic w_x_push;
  logic w_y_push;

  // Ready depends only on sel and registered occupancy, never on consumers.
  assign in_ready = sel ? ~w_y_full : ~w_x_full;
  assign w_x_push = in_valid & in_ready & ~sel;
  assign w_y_push = in_valid & in_ready & sel;

  demux1_2_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW),
    .CW    (CW)
  ) u_x_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_x_push),
    .i_data  (in_data),
    .i_ready (x_ready),
    .o_data  (x),
    .o_valid (x_valid),
    .o_full  (w_x_full),
    .o_count (x_count)
  );

  demux1_2_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW),
    .CW    (CW)
  ) u_y_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_y_push),
    .i_data  (in_data),
    .i_ready (y_ready),
    .o_data  (y),
    .o_valid (y_valid),
    .o_full  (w_y_full),
    .o_count (y_count)
  );

endmodule

// File: tb/tb_demux1_2.sv
// Directed bench for demux1_2 (WIDTH=4, DEPTH=2).
// Inputs change 1ns after each rising edge; outputs sampled before the next.
module tb_demux1_2;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_data;
  logic       sel;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] x;
  logic       x_valid;
  logic       x_ready;
  logic [3:0] y;
  logic       y_valid;
  logic       y_ready;
  logic [1:0] x_count;
  logic [1:0] y_count;

  int n_chk;
  int n_fail;

  demux1_2 #(.WIDTH(4), .DEPTH(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .sel      (sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .y        (y),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .x_count  (x_count),
    .y_count  (y_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, " x_valid"}, 32'(x_valid), 32'd0);
    chk({tag, " y_valid"}, 32'(y_valid), 32'd0);
    chk({tag, " x"}, 32'(x), 32'd0);
    chk({tag, " y"}, 32'(y), 32'd0);
    chk({tag, " x_count"}, 32'(x_count), 32'd0);
    chk({tag, " y_count"}, 32'(y_count), 32'd0);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int nxt;
    int exp_out;
    int cyc;
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_data  = '0;
    sel      = 1'b0;
    in_valid = 1'b0;
    x_ready  = 1'b0;
    y_ready  = 1'b0;
    #3;
    chk_empty("reset");
    #9 rst_n = 1'b1;
    step();
    chk_empty("idle");

    // Routing
    x_ready  = 1'b1;
    y_ready  = 1'b1;
    in_valid = 1'b1;
    sel      = 1'b0;
    in_data  = 4'h3;
    step();
    chk("route x_valid", 32'(x_valid), 32'd1);
    chk("route x", 32'(x), 32'h3);
    chk("route y_valid0", 32'(y_valid), 32'd0);
    sel     = 1'b1;
    in_data = 4'hA;
    step();
    chk("route y_valid", 32'(y_valid), 32'd1);
    chk("route y", 32'(y), 32'hA);
    chk("route x drained", 32'(x_valid), 32'd0);
    in_valid = 1'b0;
    step();
    chk("route y drained", 32'(y_valid), 32'd0);

    // Full / stall
    x_ready  = 1'b0;
    y_ready  = 1'b0;
    in_valid = 1'b1;
    sel      = 1'b0;
    in_data  = 4'h1;
    step();
    in_data = 4'h2;
    step();
    chk("full x_count", 32'(x_count), 32'd2);
    chk("full in_ready sel0", 32'(in_ready), 32'd0);
    sel     = 1'b1;
    in_data = 4'h5;
    #1;
    chk("full in_ready sel1", 32'(in_ready), 32'd1);
    step();
    chk("full y_count", 32'(y_count), 32'd1);
    chk("full y", 32'(y), 32'h5);
    chk("full x_count kept", 32'(x_count), 32'd2);

    // Full with simultaneous pop
    sel     = 1'b0;
    in_data = 4'h7;
    x_ready = 1'b1;
    #1;
    chk("fpop in_ready", 32'(in_ready), 32'd0);
    chk("fpop head1", 32'(x), 32'h1);
    step();
    chk("fpop count1", 32'(x_count), 32'd1);
    chk("fpop head2", 32'(x), 32'h2);
    step();
    chk("fpop count2", 32'(x_count), 32'd1);
    chk("fpop head7", 32'(x), 32'h7);
    in_valid = 1'b0;
    step();
    chk("fpop drained", 32'(x_valid), 32'd0);
    chk("fpop y held", 32'(y), 32'h5);
    chk("fpop y_count held", 32'(y_count), 32'd1);
    y_ready = 1'b1;
    step();
    chk("y drained", 32'(y_valid), 32'd0);
    y_ready = 1'b0;

    // Wrap-around stream with toggling x_ready
    nxt     = 0;
    exp_out = 0;
    cyc     = 0;
    sel     = 1'b0;
    while (exp_out < 10 && cyc < 80) begin
      x_ready  = cyc[0];
      in_valid = (nxt < 10);
      in_data  = 4'(nxt);
      #1;
      if (x_valid && x_ready) begin
        chk("wrap order", 32'(x), 32'(exp_out));
        exp_out++;
      end
      if (in_valid && in_ready) nxt++;
      chk("wrap count<=2", 32'(x_count <= 2'd2), 32'd1);
      step();
      cyc++;
    end
    chk("wrap all popped", 32'(exp_out), 32'd10);
    in_valid = 1'b0;
    x_ready  = 1'b0;
    step();
    chk("wrap empty", 32'(x_valid), 32'd0);

    // Empty pop on y, x holds one word
    in_valid = 1'b1;
    sel      = 1'b0;
    in_data  = 4'hC;
    step();
    in_valid = 1'b0;
    y_ready  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("epop y_valid", 32'(y_valid), 32'd0);
      chk("epop y_count", 32'(y_count), 32'd0);
      chk("epop x_count", 32'(x_count), 32'd1);
      chk("epop x", 32'(x), 32'hC);
    end
    y_ready = 1'b0;

    // Asynchronous reset with both FIFOs holding data
    in_valid = 1'b1;
    sel      = 1'b1;
    in_data  = 4'hE;
    step();
    in_valid = 1'b0;
    chk("pre-rst x_count", 32'(x_count), 32'd1);
    chk("pre-rst y_count", 32'(y_count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_empty("async rst");
    #2 rst_n = 1'b1;
    step();
    chk_empty("post rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/demux1_2.md
DEMUX1_2 -- requirements
Module: demux1_2

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning data width in bits (1..32).
REQ-002 SHALL have parameter DEPTH, default 2, meaning entries per output FIFO (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_data  input  WIDTH  input word.
REQ-006 SHALL have port sel  input  1  route select, sampled with in_data: 0 selects channel x, 1 selects channel y.
REQ-007 SHALL have port in_valid  input  1  in_data/sel valid.
REQ-008 SHALL have port in_ready  output  1  block can accept the word on the selected channel this cycle.
REQ-009 SHALL have port x  output  WIDTH  channel x head-of-FIFO data.
REQ-010 SHALL have port x_valid  output  1  channel x FIFO non-empty.
REQ-011 SHALL have port x_ready  input  1  channel x consumer accepts.
REQ-012 SHALL have port y  output  WIDTH  channel y head-of-FIFO data.
REQ-013 SHALL have port y_valid  output  1  channel y FIFO non-empty.
REQ-014 SHALL have port y_ready  input  1  channel y consumer accepts.
REQ-015 SHALL have port x_count, y_count  output  $clog2(DEPTH)+1  current occupancy of each FIFO.

Function
REQ-016 Accept SHALL occur on a rising clk edge with in_valid=1 and in_ready=1; the word SHALL be pushed into the FIFO chosen by sel at that edge.
REQ-017 in_ready SHALL equal NOT full of the FIFO selected by the current sel (combinational from sel and registered counts only; no path from x_ready/y_ready).
REQ-018 A full FIFO SHALL NOT accept a push even if it is popped in the same cycle; the push is stalled one cycle.
REQ-019 Pop SHALL occur on a rising edge with x_valid=1 and x_ready=1 (likewise for y); the head entry is removed and the next entry appears on x/y after the edge.
REQ-020 x_valid/y_valid SHALL be 1 iff the respective count is nonzero; latency from accept to valid SHALL be exactly 1 cycle (registered, no fall-through).
REQ-021 x/y SHALL present the head entry whenever valid; value when invalid is don't-care but SHALL NOT be X after reset (reads as 0 before the first write).
REQ-022 Each FIFO SHALL preserve order; channels SHALL be independent (traffic or stall on one never blocks or reorders the other, except via in_ready for the currently selected channel).
REQ-023 Each FIFO SHALL use read/write pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, plus a count of 0..DEPTH.
REQ-024 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave count unchanged and advance both pointers.
REQ-025 Simultaneous push and pop on an empty FIFO SHALL perform only the push (pop ignored, valid was 0).
REQ-026 Pop with x_valid=0 (x_ready=1) SHALL have no effect; likewise for y.
REQ-027 in_valid=0 SHALL never modify state regardless of sel.
REQ-028 Count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-029 rst_n=0 SHALL immediately (without clk) clear pointers, counts and storage: x_valid=0, y_valid=0, x=0, y=0, x_count=0, y_count=0, in_ready=1.
REQ-030 Reset asserted mid-operation SHALL discard all buffered words; no pop or push SHALL be reported on the first edge after rst_n deasserts unless in_valid/ready conditions hold on that edge.

Verification
REQ-031 Reset: drive rst_n=0 asynchronously between edges with both FIFOs holding data -> x_valid=y_valid=0, counts=0, in_ready=1 before next edge.
REQ-032 Routing: push 0x3 sel=0, then 0xA sel=1, readies=1 -> x=0x3 x_valid=1 one cycle after first accept; y=0xA one cycle after second; no crossover.
REQ-033 Full/stall (DEPTH=2): x_ready=0, push 0x1,0x2 sel=0 -> x_count=2, in_ready=0 with sel=0 and in_ready=1 with sel=1; push 0x5 sel=1 accepted into y.
REQ-034 Full with simultaneous pop: x full, x_ready=1, in_valid=1 sel=0 data 0x7 -> first edge pops 0x1 only (count 1), 0x7 accepted next edge; output order 0x1,0x2,0x7.
REQ-035 Wrap-around: stream 10 words 0x0..0x9 sel=0 with x_ready toggling 1/0 each cycle -> x sequence 0x0..0x9 in order, count never >2.
REQ-036 Empty pop: y empty, y_ready=1 for 5 cycles -> y_valid=0, y_count=0 throughout, x channel unaffected.
